// File: rtl/ei_axi4_slave_write_responder.sv
// ---------------------------------------------------------------------------
// ei_axi4_slave_write_responder
//
// Single-outstanding AXI4 write slave backed by a byte-lane-writable memory.
// One AW is taken in IDLE, its beats are taken in DATA, and one B response is
// returned in RESP. Each beat's address and expected strobe are derived from
// the latched burst parameters. Illegal bursts, stray strobe bits and
// misplaced wlast all produce SLVERR instead of stalling the bus.
//
// Handshake rule, used on every channel: a transfer happens on a rising aclk
// edge where valid and ready are both high. valid never waits for ready.
// Once bvalid is raised, bvalid, bresp and bid hold steady until the B
// transfer completes.
//
// Ports
//   aclk, areset        clock, asynchronous active-high reset
//   aw*                 write address channel (awburst 0 FIXED, 1 INCR, 2 WRAP)
//   w*                  write data channel
//   b*                  write response channel
//   dbg_addr/dbg_rdata  combinational backdoor read of one memory word
//   dbg_state           current FSM state (0 IDLE, 1 DATA, 2 RESP)
// ---------------------------------------------------------------------------
module ei_axi4_slave_write_responder #(
    parameter int unsigned BUS_BYTE_LANES = 4,
    parameter int unsigned MEM_DEPTH      = 256,
    parameter int unsigned ID_WIDTH       = 4
) (
    input  logic                          aclk,
    input  logic                          areset,
    // write address channel
    input  logic                          awvalid,
    output logic                          awready,
    input  logic [31:0]                   awaddr,
    input  logic [7:0]                    awlen,
    input  logic [2:0]                    awsize,
    input  logic [1:0]                    awburst,
    input  logic [ID_WIDTH-1:0]           awid,
    // write data channel
    input  logic                          wvalid,
    output logic                          wready,
    input  logic [8*BUS_BYTE_LANES-1:0]   wdata,
    input  logic [BUS_BYTE_LANES-1:0]     wstrb,
    input  logic                          wlast,
    // write response channel
    output logic                          bvalid,
    input  logic                          bready,
    output logic [1:0]                    bresp,
    output logic [ID_WIDTH-1:0]           bid,
    // backdoor
    input  logic [31:0]                   dbg_addr,
    output logic [8*BUS_BYTE_LANES-1:0]   dbg_rdata,
    output logic [1:0]                    dbg_state
);

    localparam int unsigned DATA_W    = 8 * BUS_BYTE_LANES;
    localparam int unsigned OFF_W     = $clog2(BUS_BYTE_LANES);
    localparam int unsigned IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [31:0] LANE_MASK = 32'(BUS_BYTE_LANES - 1);

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic                live_q, live_d;     // low until the first edge after reset
    logic [31:0]         addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic [2:0]          size_q, size_d;
    logic [1:0]          burst_q, burst_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [7:0]          beat_q, beat_d;
    logic                err_q, err_d;
    logic                nowr_q, nowr_d;     // burst judged illegal at AW: no writes

    logic [DATA_W-1:0]   mem_q [MEM_DEPTH];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= ST_IDLE;
            live_q  <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            id_q    <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            nowr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= live_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            id_q    <= id_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            nowr_q  <= nowr_d;
        end
    end

    // ------------------------------------------------------------------
    // Beat address for the current beat_q
    // ------------------------------------------------------------------
    logic [31:0] size_bytes;
    logic [31:0] size_mask;
    logic [31:0] step;
    logic [31:0] wrap_total;
    logic [31:0] wrap_lower;
    logic [31:0] wrap_off;
    logic [31:0] beat_addr;

    always_comb begin
        size_bytes = 32'd1 << size_q;
        size_mask  = size_bytes - 32'd1;
        step       = {24'd0, beat_q} << size_q;
        wrap_total = ({24'd0, len_q} + 32'd1) << size_q;
        wrap_lower = addr_q & ~(wrap_total - 32'd1);
        // Work as an offset inside the wrap window so the boundary test never
        // depends on lower+total overflowing at the top of the address space.
        wrap_off   = (addr_q - wrap_lower) + step;
        if (wrap_off >= wrap_total) begin
            wrap_off = wrap_off - wrap_total;
        end
        beat_addr = addr_q;
        case (burst_q)
            BURST_FIXED: beat_addr = addr_q;
            BURST_INCR:  beat_addr = (beat_q == 8'd0) ? addr_q
                                                      : (addr_q & ~size_mask) + step;
            BURST_WRAP:  beat_addr = wrap_lower + wrap_off;
            default:     beat_addr = addr_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Expected strobe: S lanes starting at the size-aligned lane. Beats that
    // may start unaligned (FIXED, first INCR beat) begin at the true byte lane.
    // ------------------------------------------------------------------
    logic                      unaligned_start;
    logic [31:0]               lane_lo_al;
    logic [31:0]               lane_lo;
    logic [31:0]               lane_hi;
    logic [BUS_BYTE_LANES-1:0] exp_strb;

    always_comb begin
        unaligned_start = (burst_q == BURST_FIXED) ||
                          ((burst_q == BURST_INCR) && (beat_q == 8'd0));
        lane_lo_al = (beat_addr & ~size_mask) & LANE_MASK;
        lane_hi    = lane_lo_al + size_bytes;
        lane_lo    = unaligned_start ? (beat_addr & LANE_MASK) : lane_lo_al;
        exp_strb   = '0;
        for (int i = 0; i < BUS_BYTE_LANES; i++) begin
            exp_strb[i] = (32'(i) >= lane_lo) && (32'(i) < lane_hi);
        end
    end

    logic [IDX_W-1:0] mem_idx;
    logic [IDX_W-1:0] dbg_idx;

    assign mem_idx = IDX_W'((beat_addr >> OFF_W) % MEM_DEPTH);
    assign dbg_idx = IDX_W'((dbg_addr >> OFF_W) % MEM_DEPTH);

    // ------------------------------------------------------------------
    // Burst legality, judged on the incoming AW
    // ------------------------------------------------------------------
    logic aw_bad;

    always_comb begin
        aw_bad = 1'b0;
        if (awburst == BURST_RSVD) begin
            aw_bad = 1'b1;
        end
        if (32'(awsize) > OFF_W) begin
            aw_bad = 1'b1;
        end
        if (awburst == BURST_WRAP) begin
            if (!(awlen inside {8'd1, 8'd3, 8'd7, 8'd15})) begin
                aw_bad = 1'b1;
            end
            if ((awaddr & ((32'd1 << awsize) - 32'd1)) != 32'd0) begin
                aw_bad = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    logic                      last_beat;
    logic                      mem_we;
    logic [BUS_BYTE_LANES-1:0] mem_be;

    assign last_beat = (beat_q == len_q);

    always_comb begin
        state_d = state_q;
        live_d  = 1'b1;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        id_d    = id_q;
        beat_d  = beat_q;
        err_d   = err_q;
        nowr_d  = nowr_q;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = 2'b00;
        mem_we  = 1'b0;
        mem_be  = '0;

        case (state_q)
            ST_IDLE: begin
                awready = live_q;
                if (awvalid && live_q) begin
                    addr_d  = awaddr;
                    len_d   = awlen;
                    size_d  = awsize;
                    burst_d = awburst;
                    id_d    = awid;
                    beat_d  = 8'd0;
                    err_d   = aw_bad;
                    nowr_d  = aw_bad;
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    // Burst length comes from awlen alone; wlast is only checked.
                    beat_d = beat_q + 8'd1;
                    if ((wstrb & ~exp_strb) != '0) begin
                        err_d = 1'b1;
                    end
                    if (wlast != last_beat) begin
                        err_d = 1'b1;
                    end
                    mem_we = !nowr_q;
                    mem_be = wstrb & exp_strb;
                    if (last_beat) begin
                        state_d = ST_RESP;
                    end
                end
            end

            ST_RESP: begin
                bvalid = 1'b1;
                bresp  = err_q ? 2'b10 : 2'b00;
                if (bready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bid       = id_q;
    assign dbg_state = state_q;

    // ------------------------------------------------------------------
    // Memory: byte-lane writes on the W handshake; never cleared by reset.
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int i = 0; i < BUS_BYTE_LANES; i++) begin
                if (mem_be[i]) begin
                    mem_q[mem_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign dbg_rdata = mem_q[dbg_idx];

endmodule
